// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving a CPU port and a debug/loader port shared use of one memory port.
// One access per MEM_LAT+2 cycles. A requester waits with no ack until its access completes.
module mem_arbiter #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 8,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,

   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              dbg_lock,

   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,

   output logic              owner
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   logic [1:0]        state;
   logic [3:0]        cnt;
   logic              owner_q;
   logic              last_dbg;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              cpu_elig;
   logic              dbg_elig;
   logic              grant_dbg;

   // dbg_lock only holds back new CPU grants; an access already running is unaffected.
   assign cpu_elig  = cpu_req & ~dbg_lock;
   assign dbg_elig  = dbg_req;
   assign grant_dbg = dbg_elig & (~cpu_elig | ~last_dbg);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         owner_q   <= 1'b0;
         last_dbg  <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cpu_elig | dbg_elig) begin
                  state    <= ACCESS;
                  owner_q  <= grant_dbg;
                  last_dbg <= grant_dbg;
                  we_q     <= grant_dbg ? dbg_we    : cpu_we;
                  addr_q   <= grant_dbg ? dbg_addr  : cpu_addr;
                  wdata_q  <= grant_dbg ? dbg_wdata : cpu_wdata;
                  cnt      <= LAT_LOAD;
               end
            end
            ACCESS: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
                  if (!we_q) begin
                     if (owner_q) dbg_rdata <= mem_rdata;
                     else         cpu_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Memory strobes are decoded from state so an asynchronous reset drops them at once.
   assign mem_en    = (state == ACCESS);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   assign cpu_ack   = (state == RESP) & ~owner_q;
   assign dbg_ack   = (state == RESP) &  owner_q;
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign owner     = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-port traffic, checked by a
// transaction-level model and scoreboard; a second instance exercises the one-cycle latency build.
`timescale 1ns/1ps
module tb_mem_arbiter;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic          req_v   [2];
   logic          we_v    [2];
   logic [AW-1:0] addr_v  [2];
   logic [DW-1:0] wdata_v [2];
   logic          dbg_lock;

   logic          cpu_ack, dbg_ack, cpu_stall, owner;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [DW-1:0] mem_arr [256];

   // second instance, MEM_LAT = 1, CPU port only
   logic          c1_req, c1_we;
   logic [AW-1:0] c1_addr;
   logic [DW-1:0] c1_wdata;
   logic          c1_ack, c1_stall, d1_ack, owner1;
   logic [DW-1:0] c1_rdata, d1_rdata;
   logic          m1_en, m1_we;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [DW-1:0] mem1 [256];

   int total = 0;
   int bad   = 0;

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(req_v[0]), .cpu_we(we_v[0]), .cpu_addr(addr_v[0]), .cpu_wdata(wdata_v[0]),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(req_v[1]), .dbg_we(we_v[1]), .dbg_addr(addr_v[1]), .dbg_wdata(wdata_v[1]),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_lock(dbg_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .owner(owner)
   );

   mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
      .cpu_ack(c1_ack), .cpu_rdata(c1_rdata), .cpu_stall(c1_stall),
      .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(8'h00), .dbg_wdata(32'h0),
      .dbg_ack(d1_ack), .dbg_rdata(d1_rdata), .dbg_lock(1'b0),
      .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
      .mem_rdata(m1_rdata), .owner(owner1)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      return 32'hC0DE0000 ^ (32'(a) * 32'h00010003);
   endfunction

   // memories: contents restored to a known pattern whenever reset is sampled low
   assign mem_rdata = mem_arr[mem_addr];
   assign m1_rdata  = mem1[m1_addr];
   always @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 256; i++) begin
            mem_arr[i] <= init_val(i);
            mem1[i]    <= init_val(i);
         end
      end else begin
         if (mem_en && mem_we) mem_arr[mem_addr] <= mem_wdata;
         if (m1_en && m1_we)   mem1[m1_addr]     <= m1_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string name, input int cycles);
      total++;
      bad++;
      $display("FAIL %s: no ack after %0d cycles, expected one", name, cycles);
   endtask

   function automatic logic ack_of(input int p);
      return (p == 1) ? dbg_ack : cpu_ack;
   endfunction

   // ---------------- reference model: one transaction per grant ----------------
   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] rdata;
      int            g;
   } xact_t;

   xact_t         exp_q[$];
   int            edge_n = 0;
   logic [DW-1:0] ref_mem [256];

   initial begin
      int            free_at;
      int            last_p;
      int            p;
      logic          ce, de;
      logic [DW-1:0] exp_rd [2];
      xact_t         x;
      free_at   = 0;
      last_p    = 1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      forever begin
         @(posedge clk);
         edge_n++;
         if (!reset) begin
            exp_q.delete();
            free_at   = 0;
            last_p    = 1;
            exp_rd[0] = '0;
            exp_rd[1] = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
         end else if (edge_n >= free_at) begin
            ce = req_v[0] && !dbg_lock;
            de = req_v[1];
            if (ce || de) begin
               if (ce && de) p = 1 - last_p;
               else          p = de ? 1 : 0;
               x.port  = p;
               x.we    = we_v[p];
               x.addr  = addr_v[p];
               x.wdata = wdata_v[p];
               if (x.we) ref_mem[x.addr] = x.wdata;
               else      exp_rd[p] = ref_mem[x.addr];
               x.rdata = exp_rd[p];
               x.g     = edge_n;
               exp_q.push_back(x);
               last_p  = p;
               free_at = edge_n + LAT + 2;
            end
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic  ea_c, ea_d, een;
      xact_t f;
      f = '{port: 0, we: 1'b0, addr: '0, wdata: '0, rdata: '0, g: 0};
      forever begin
         @(negedge clk);
         #1;
         ea_c = 1'b0;
         ea_d = 1'b0;
         een  = 1'b0;
         if (exp_q.size() > 0) begin
            f = exp_q[0];
            if (edge_n >= f.g && edge_n < f.g + LAT) een = 1'b1;
            if (edge_n == f.g + LAT) begin
               if (f.port == 0) ea_c = 1'b1;
               else             ea_d = 1'b1;
            end
         end
         chk("cpu_ack", 32'(cpu_ack), 32'(ea_c));
         chk("dbg_ack", 32'(dbg_ack), 32'(ea_d));
         chk("mem_en", 32'(mem_en), 32'(een));
         chk("mem_we", 32'(mem_we), 32'(een && f.we));
         chk("cpu_stall", 32'(cpu_stall), 32'(req_v[0] && !ea_c));
         if (een) begin
            chk("mem_addr", 32'(mem_addr), 32'(f.addr));
            chk("mem_wdata", mem_wdata, f.wdata);
            chk("owner_access", 32'(owner), 32'(f.port));
         end
         if (ea_c || ea_d) begin
            chk("rdata_at_ack", (f.port == 1) ? dbg_rdata : cpu_rdata, f.rdata);
            chk("owner_at_ack", 32'(owner), 32'(f.port));
            void'(exp_q.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic req_wait(input int p, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic [DW-1:0] rd,
                           output logic stall, output int t);
      logic done;
      we_v[p]    = we;
      addr_v[p]  = a;
      wdata_v[p] = d;
      req_v[p]   = 1'b1;
      t     = 0;
      rd    = '0;
      stall = 1'b1;
      done  = 1'b0;
      while (!done && t < 200) begin
         @(negedge clk);
         t++;
         if (ack_of(p)) begin
            rd    = (p == 1) ? dbg_rdata : cpu_rdata;
            stall = cpu_stall;
            done  = 1'b1;
         end
      end
      req_v[p] = 1'b0;
      if (!done) timeout_fail("req_wait", t);
   endtask

   task automatic drive_port(input int p, input int n_ops);
      int   ops;
      int   t;
      int   drop_at;
      logic keep;
      logic abandon;
      logic done;
      ops  = 0;
      keep = 1'b0;
      while (ops < n_ops) begin
         if (!keep) repeat ($urandom_range(0, 4)) @(negedge clk);
         we_v[p]    = 1'($urandom_range(0, 1));
         addr_v[p]  = 8'($urandom_range(0, 15));
         wdata_v[p] = $urandom;
         req_v[p]   = 1'b1;
         abandon    = ($urandom_range(0, 9) == 0);
         drop_at    = $urandom_range(1, 3);
         keep       = 1'b0;
         done       = 1'b0;
         t          = 0;
         while (!done) begin
            @(negedge clk);
            t++;
            if (ack_of(p)) begin
               keep = 1'($urandom_range(0, 1));
               if (!keep) req_v[p] = 1'b0;
               done = 1'b1;
            end else if (abandon && t == drop_at) begin
               // leave room for an already-granted access to finish before re-requesting
               req_v[p] = 1'b0;
               repeat (LAT + 3) @(negedge clk);
               done = 1'b1;
            end else if (t > 400) begin
               timeout_fail("random_req", t);
               req_v[p] = 1'b0;
               done     = 1'b1;
               ops      = n_ops;
            end
         end
         ops++;
      end
      req_v[p] = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int            order [4];
      int            at    [4];
      int            n, t, en_cnt, en_first, a1_0, a1_1;
      logic [DW-1:0] rd, rd1;
      logic          stall;
      logic          rand_stop;

      reset = 1'b0;
      dbg_lock = 1'b0;
      rand_stop = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
         order[i] = 0; order[i+2] = 0; at[i] = 0; at[i+2] = 0;
      end
      c1_req = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;

      // both ports request straight out of reset
      req_v[0] = 1'b1; addr_v[0] = 8'h01;
      req_v[1] = 1'b1; addr_v[1] = 8'h02;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_dbg_ack", 32'(dbg_ack), 32'd0);
      chk("rst_cpu_rdata", cpu_rdata, 32'd0);
      chk("rst_dbg_rdata", dbg_rdata, 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      #1 reset = 1'b1;

      n = 0; t = 0;
      while (n < 4 && t < 60) begin
         @(negedge clk);
         t++;
         if (cpu_ack || dbg_ack) begin
            order[n] = dbg_ack ? 1 : 0;
            at[n]    = t;
            n++;
         end
      end
      req_v[0] = 1'b0; req_v[1] = 1'b0;
      chk("rr_ack_count", 32'(n), 32'd4);
      for (int i = 0; i < n; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
      for (int i = 1; i < n; i++) chk("rr_spacing", 32'(at[i] - at[i-1]), 32'd4);

      // debug loads DEADBEEF at 0x10, CPU reads it back
      repeat (2) @(negedge clk);
      req_wait(1, 1'b1, 8'h10, 32'hDEADBEEF, rd, stall, t);
      repeat (2) @(negedge clk);
      req_wait(0, 1'b0, 8'h10, 32'h0, rd, stall, t);
      chk("read_10_data", rd, 32'hDEADBEEF);
      chk("read_10_latency", 32'(t), 32'(LAT + 1));
      chk("stall_at_ack", 32'(stall), 32'd0);
      #1 chk("stall_after_ack", 32'(cpu_stall), 32'd0);

      // dbg_lock holds off the CPU while the loader writes
      repeat (2) @(negedge clk);
      dbg_lock = 1'b1;
      we_v[0] = 1'b0; addr_v[0] = 8'h20; req_v[0] = 1'b1;
      req_wait(1, 1'b1, 8'h20, 32'h5A5A5A5A, rd, stall, t);
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (cpu_ack) n++;
      end
      chk("lock_no_cpu_ack", 32'(n), 32'd0);
      chk("lock_mem_20", mem_arr[8'h20], 32'h5A5A5A5A);
      dbg_lock = 1'b0;
      n = 0; t = 0;
      while (n == 0 && t < 20) begin
         @(negedge clk);
         t++;
         if (cpu_ack) begin
            n++;
            rd = cpu_rdata;
         end
      end
      req_v[0] = 1'b0;
      chk("unlock_cpu_ack", 32'(n), 32'd1);
      chk("unlock_cpu_rdata", rd, 32'h5A5A5A5A);

      // CPU drops its request during the first access cycle
      repeat (2) @(negedge clk);
      we_v[0] = 1'b0; addr_v[0] = 8'h05; req_v[0] = 1'b1;
      t = 0;
      while (!mem_en && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("drop_saw_access", 32'(mem_en), 32'd1);
      req_v[0] = 1'b0;
      n = 0;
      repeat (10) begin
         @(negedge clk);
         if (cpu_ack) n++;
      end
      chk("drop_ack_once", 32'(n), 32'd1);

      // randomized traffic on both ports with dbg_lock toggling
      fork
         begin
            while (!rand_stop) begin
               dbg_lock = ($urandom_range(0, 3) == 0);
               repeat ($urandom_range(1, 12)) @(negedge clk);
            end
            dbg_lock = 1'b0;
         end
         begin
            fork
               drive_port(0, 40);
               drive_port(1, 40);
            join
            rand_stop = 1'b1;
         end
      join
      repeat (8) @(negedge clk);

      // reset in the second access cycle of a CPU write
      we_v[0] = 1'b1; addr_v[0] = 8'h30; wdata_v[0] = 32'h0BADF00D; req_v[0] = 1'b1;
      t = 0;
      while (!mem_en && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("rstmid_saw_access", 32'(mem_en), 32'd1);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rstmid_mem_en", 32'(mem_en), 32'd0);
      chk("rstmid_mem_we", 32'(mem_we), 32'd0);
      chk("rstmid_cpu_ack", 32'(cpu_ack), 32'd0);
      req_v[0] = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (cpu_ack || mem_en) n++;
      end
      chk("rstmid_idle_after", 32'(n), 32'd0);
      chk("rstmid_owner", 32'(owner), 32'd0);
      chk("rstmid_cpu_rdata", cpu_rdata, 32'd0);

      // MEM_LAT=1 instance: read then write back-to-back with request held
      c1_we = 1'b0; c1_addr = 8'h33; c1_wdata = '0; c1_req = 1'b1;
      t = 0; n = 0; en_cnt = 0; en_first = -1; a1_0 = 0; a1_1 = 0; rd1 = '0;
      while (n < 2 && t < 50) begin
         @(negedge clk);
         t++;
         if (m1_en) begin
            en_cnt++;
            if (en_first < 0) en_first = t;
         end
         if (c1_ack) begin
            if (n == 0) begin
               a1_0     = t;
               rd1      = c1_rdata;
               c1_we    = 1'b1;
               c1_wdata = 32'hCAFEF00D;
            end else begin
               a1_1 = t;
            end
            n++;
         end
      end
      c1_req = 1'b0;
      chk("l1_ack_count", 32'(n), 32'd2);
      chk("l1_ack_after_access", 32'(a1_0 - en_first), 32'd1);
      chk("l1_period", 32'(a1_1 - a1_0), 32'd3);
      chk("l1_en_cycles", 32'(en_cnt), 32'd2);
      chk("l1_read_data", rd1, init_val(32'h33));
      chk("l1_rdata_kept", c1_rdata, init_val(32'h33));
      chk("l1_mem_written", mem1[8'h33], 32'hCAFEF00D);

      repeat (10) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the data width of all wdata, rdata and mem data ports.
REQ-002 Parameter ADDR_W, default 8, SHALL set the width of all address ports.
REQ-003 Parameter MEM_LAT, default 2, legal range 1..15, SHALL set the number of cycles mem_en is held for each access.
REQ-004 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset: low clears all state immediately.
REQ-006 cpu_req  input  1  SHALL be the CPU-port access request, held until cpu_ack.
REQ-007 cpu_we, cpu_addr[ADDR_W], cpu_wdata[DATA_W]  input  SHALL be the CPU write flag, address and write data, stable while cpu_req is high.
REQ-008 cpu_ack  output  1  SHALL be a one-cycle completion pulse; cpu_rdata[DATA_W]  output  SHALL hold read data.
REQ-009 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata SHALL mirror the CPU port signals for the debug/loader port.
REQ-010 dbg_lock  input  1  SHALL, when high, block new CPU grants (CPU halt for program loading).
REQ-011 mem_en, mem_we  output  1, mem_addr[ADDR_W], mem_wdata[DATA_W]  output, mem_rdata[DATA_W]  input  SHALL form the shared memory port.
REQ-012 cpu_stall  output  1  SHALL equal cpu_req AND NOT cpu_ack.
REQ-013 owner  output  1  SHALL report the current or last granted port (0 = CPU, 1 = dbg).

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-015 In IDLE, at a rising edge with an eligible request, the FSM SHALL latch owner, we, addr and wdata of the winner and enter ACCESS; without one it SHALL stay in IDLE.
REQ-016 The CPU SHALL be eligible when cpu_req=1 and dbg_lock=0; dbg SHALL be eligible when dbg_req=1.
REQ-017 If both ports are eligible, the port not granted last SHALL win (round robin); a single eligible port SHALL always win.
REQ-018 In ACCESS, mem_en SHALL be 1, and mem_we, mem_addr and mem_wdata SHALL be driven from latched values for exactly MEM_LAT cycles, using a down-counter loaded with MEM_LAT-1.
REQ-019 At the edge ending the last ACCESS cycle, mem_rdata SHALL be captured into the owner's rdata register for reads; for writes the owner's rdata SHALL be left unchanged. The FSM SHALL then enter RESP.
REQ-020 In RESP, the owner's ack SHALL be 1 for one cycle, mem_en and mem_we SHALL be 0, and the FSM SHALL return to IDLE at the next edge.
REQ-021 Latency SHALL be MEM_LAT+1 edges from request sampling to ack, and throughput SHALL be one access per MEM_LAT+2 cycles; no grant SHALL occur in RESP.
REQ-022 Outside ACCESS, mem_en and mem_we SHALL be 0.
REQ-023 rdata registers SHALL hold their value until the next read by the same port.
REQ-024 A requester dropping req mid-access SHALL NOT abort the access; ack SHALL still pulse.
REQ-025 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-026 dbg_lock rising during a CPU access SHALL NOT abort it; it SHALL only gate subsequent CPU grants.
REQ-027 The non-owner's ack SHALL stay 0 throughout.

Reset
REQ-028 While reset=0: state=IDLE, mem_en=mem_we=0, mem_addr=mem_wdata=0, cpu_ack=dbg_ack=0, cpu_rdata=dbg_rdata=0, counter=0, and last-granted=dbg so the CPU wins the first tie; owner SHALL read 0.
REQ-029 Reset asserted mid-ACCESS SHALL drop mem_en and mem_we asynchronously and discard the transaction with no ack.
REQ-030 After reset releases, the first grant SHALL occur no earlier than the first rising edge with reset=1.

Verification
REQ-031 MEM_LAT=2, mem[0x10]=0xDEADBEEF, cpu read 0x10 -> mem_en high 2 cycles, cpu_ack pulses on the 3rd edge after sampling, cpu_rdata=0xDEADBEEF, cpu_stall low from ack onward.
REQ-032 cpu_req and dbg_req high together from reset, both held -> grant order CPU, dbg, CPU, dbg, with acks alternating every 4 cycles.
REQ-033 dbg_lock=1, cpu_req=1, dbg writes 0x5A5A5A5A to 0x20 -> only dbg grants, mem_we high 2 cycles at addr 0x20, cpu_ack stays 0 until dbg_lock=0.
REQ-034 reset=0 in the 2nd ACCESS cycle of a CPU write -> mem_en and mem_we are 0 in the same cycle, no cpu_ack, state IDLE after release.
REQ-035 MEM_LAT=1, CPU read then CPU write back-to-back with req held -> each access is 3 cycles, cpu_rdata is unchanged by the write.
REQ-036 cpu_req drops in the 1st ACCESS cycle -> the access completes, cpu_ack pulses once, and no further grant occurs.
